duty_ramp: RTL and testbench

Soft-start / slew-rate limiter that sits directly upstream of the PWM generator and drives its 7-bit duty-cycle input. A requested duty in percent (0–100) is captured on a load strobe. The output duty then walks toward it by a fixed step every programmable number of clock cycles, so the PWM output never jumps abruptly. Status outputs report when a ramp is in progress and when it has completed.

---
 rtl/duty_ramp_if.sv | 23 ++
 rtl/duty_ramp.sv | 95 +++++++++
 tb/tb_duty_ramp.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/duty_ramp_if.sv
// Control/status bundle between the duty-ramp limiter and whatever programs it.
// The kill wire only exists when DUTY_RAMP_KILL_EN is defined.
interface duty_ramp_if #(
  parameter int RATE_W = 8
);
  logic [6:0]        target;
  logic              load;
  logic [RATE_W-1:0] rate;
`ifdef DUTY_RAMP_KILL_EN
  logic              kill;
`endif
  logic [6:0]        dc;
  logic              busy;
  logic              done;

`ifdef DUTY_RAMP_KILL_EN
  modport master (output target, load, rate, kill, input dc, busy, done);
  modport slave  (input target, load, rate, kill, output dc, busy, done);
`else
  modport master (output target, load, rate, input dc, busy, done);
  modport slave  (input target, load, rate, output dc, busy, done);
`endif
endinterface

// File: rtl/duty_ramp.sv
// Soft-start / slew limiter for the PWM duty input: walks dc toward a captured
// target by STEP percent every rate+1 clocks. Optional kill input: DUTY_RAMP_KILL_EN.
module duty_ramp #(
  parameter int STEP   = 1,
  parameter int RATE_W = 8
) (
  input logic       clk,
  input logic       reset,
  duty_ramp_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    UP   = 2'd1,
    DOWN = 2'd2
  } state_t;

  localparam logic [7:0] STEP_W   = 8'(STEP);
  localparam logic [6:0] DUTY_MAX = 7'd100;

  state_t            state;
  logic [6:0]        tgt_q;
  logic [6:0]        dc_q;
  logic [RATE_W-1:0] pcnt;
  logic              done_q;

  logic [6:0] tgt_clamped;
  logic [7:0] up_sum;
  logic [7:0] down_limit;
  logic [6:0] dc_step;
  logic       tick;

  // Stepping is done in 8 bits so dc+STEP cannot wrap and dc-STEP is only
  // taken when it is known to stay at or above the target.
  always_comb begin
    tgt_clamped = (bus.target > DUTY_MAX) ? DUTY_MAX : bus.target;
    up_sum      = {1'b0, dc_q} + STEP_W;
    down_limit  = {1'b0, tgt_q} + STEP_W;
    dc_step     = dc_q;
    tick        = (state != IDLE) && (pcnt == bus.rate);
    if (state == UP) begin
      dc_step = (up_sum >= {1'b0, tgt_q}) ? tgt_q : up_sum[6:0];
    end else if (state == DOWN) begin
      dc_step = ({1'b0, dc_q} <= down_limit) ? tgt_q : (dc_q - STEP_W[6:0]);
    end
  end

  // NOTE: every register here is assigned with <= so all of them sample the
  // pre-edge values; a blocking write would leak a new dc into the same edge.
  always_ff @(posedge clk or negedge reset) begin
    // NOTE: only real state registers exist here, so all are cleared
    // asynchronously; nothing in this block is memory-like.
    if (!reset) begin
      state  <= IDLE;
      tgt_q  <= '0;
      dc_q   <= '0;
      pcnt   <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
`ifdef DUTY_RAMP_KILL_EN
      if (bus.kill) begin
        state <= IDLE;
        tgt_q <= '0;
        dc_q  <= '0;
        pcnt  <= '0;
      end else
`endif
      if (bus.load) begin
        // Load beats a coincident tick: direction is taken from the present dc.
        tgt_q <= tgt_clamped;
        pcnt  <= '0;
        if (tgt_clamped > dc_q)      state <= UP;
        else if (tgt_clamped < dc_q) state <= DOWN;
        else                         state <= IDLE;
      end else if (tick) begin
        pcnt <= '0;
        dc_q <= dc_step;
        if (dc_step == tgt_q) begin
          state  <= IDLE;
          done_q <= 1'b1;
        end
      end else if (state != IDLE) begin
        pcnt <= pcnt + RATE_W'(1);
      end else begin
        pcnt <= '0;
      end
    end
  end

  assign bus.dc   = dc_q;
  assign bus.busy = (state != IDLE);
  assign bus.done = done_q;

endmodule

// File: tb/tb_duty_ramp.sv
// Bench for duty_ramp: two instances (STEP=1 and STEP=25) share one stimulus
// stream and are compared every cycle against an arithmetic model of the ramp.
module tb_duty_ramp;

  localparam int RATE_W = 8;
  localparam int STEP_A = 1;
  localparam int STEP_B = 25;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic [6:0]        target = '0;
  logic              load   = 1'b0;
  logic [RATE_W-1:0] rate   = '0;
  logic              kill   = 1'b0;

  int total = 0;
  int bad   = 0;
  int done_a_cnt = 0;
  int done_b_cnt = 0;

  always #5 clk = ~clk;

  duty_ramp_if #(.RATE_W(RATE_W)) bus_a ();
  duty_ramp_if #(.RATE_W(RATE_W)) bus_b ();

  assign bus_a.target = target;
  assign bus_a.load   = load;
  assign bus_a.rate   = rate;
  assign bus_b.target = target;
  assign bus_b.load   = load;
  assign bus_b.rate   = rate;
`ifdef DUTY_RAMP_KILL_EN
  assign bus_a.kill   = kill;
  assign bus_b.kill   = kill;
`endif

  duty_ramp #(.STEP(STEP_A), .RATE_W(RATE_W)) dut_a (.clk(clk), .reset(reset), .bus(bus_a));
  duty_ramp #(.STEP(STEP_B), .RATE_W(RATE_W)) dut_b (.clk(clk), .reset(reset), .bus(bus_b));

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: target, present duty, cycles since the last step.
  int m_dc[2], m_tgt[2], m_cnt[2];
  bit m_busy[2], m_done[2];

  task automatic model_step(input int k);
    int step;
    int t;
    step = (k == 0) ? STEP_A : STEP_B;
    m_done[k] = 1'b0;
    if (!reset || kill) begin
      m_dc[k] = 0; m_tgt[k] = 0; m_cnt[k] = 0; m_busy[k] = 1'b0;
    end else if (load) begin
      t = int'(target);
      m_tgt[k]  = (t > 100) ? 100 : t;
      m_busy[k] = (m_tgt[k] != m_dc[k]);
      m_cnt[k]  = 0;
    end else if (m_busy[k]) begin
      if (m_cnt[k] == int'(rate)) begin
        m_cnt[k] = 0;
        if (m_dc[k] < m_tgt[k]) m_dc[k] = (m_dc[k] + step > m_tgt[k]) ? m_tgt[k] : m_dc[k] + step;
        else                    m_dc[k] = (m_dc[k] - step < m_tgt[k]) ? m_tgt[k] : m_dc[k] - step;
        if (m_dc[k] == m_tgt[k]) begin
          m_busy[k] = 1'b0;
          m_done[k] = 1'b1;
        end
      end else begin
        m_cnt[k]++;
      end
    end
  endtask

  always @(posedge clk) begin
    model_step(0);
    model_step(1);
  end

  // Compare process: outputs settle right after the edge.
  always @(posedge clk) begin
    #1;
    check("a_dc",   int'(bus_a.dc),   m_dc[0]);
    check("a_busy", int'(bus_a.busy), int'(m_busy[0]));
    check("a_done", int'(bus_a.done), int'(m_done[0]));
    check("b_dc",   int'(bus_b.dc),   m_dc[1]);
    check("b_busy", int'(bus_b.busy), int'(m_busy[1]));
    check("b_done", int'(bus_b.done), int'(m_done[1]));
    if (bus_a.done) done_a_cnt++;
    if (bus_b.done) done_b_cnt++;
  end

  // Called at a negedge; returns at the negedge after the load edge.
  task automatic do_load(input int t);
    target = 7'(t);
    load   = 1'b1;
    @(negedge clk);
    load   = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    int d0;
    int db;
    int lim;

    // Reset then idle.
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (20) @(negedge clk);
    check("idle_dc", int'(bus_a.dc), 0);
    check("idle_busy", int'(bus_a.busy), 0);
    check("idle_done_cnt", done_a_cnt, 0);

    // Ramp up 0 -> 10, one step per clock.
    rate = '0;
    do_load(10);
    check("up_busy0", int'(bus_a.busy), 1);
    check("up_dc0", int'(bus_a.dc), 0);
    d0 = done_a_cnt;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      check("up_dc", int'(bus_a.dc), i);
      if (i < 10) check("up_busy", int'(bus_a.busy), 1);
    end
    check("up_done_hi", int'(bus_a.done), 1);
    check("up_busy_lo", int'(bus_a.busy), 0);
    @(negedge clk);
    check("up_done_lo", int'(bus_a.done), 0);
    check("up_done_cnt", done_a_cnt - d0, 1);

    // Clamp and prescale on the STEP=25 instance.
    do_reset();
    rate = 8'd3;
    db = done_b_cnt;
    do_load(120);
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      if (k % 4 == 0) check("clamp_dc", int'(bus_b.dc), 25 * (k / 4));
      if (k == 15) check("clamp_dc15", int'(bus_b.dc), 75);
    end
    check("clamp_done", int'(bus_b.done), 1);
    repeat (4) @(negedge clk);
    check("clamp_dc_hold", int'(bus_b.dc), 100);
    check("clamp_done_cnt", done_b_cnt - db, 1);

    // Retarget down mid-ramp.
    do_reset();
    rate = '0;
    d0 = done_a_cnt;
    do_load(50);
    for (int i = 0; i < 200 && bus_a.dc != 7'd20; i++) @(negedge clk);
    check("rt_reach20", int'(bus_a.dc), 20);
    do_load(5);
    check("rt_load_nostep", int'(bus_a.dc), 20);
    repeat (30) @(negedge clk);
    check("rt_dc", int'(bus_a.dc), 5);
    check("rt_done_cnt", done_a_cnt - d0, 1);

    // Same-value load, then load/tick collision.
    do_load(40);
    repeat (40) @(negedge clk);
    check("sv_dc", int'(bus_a.dc), 40);
    d0 = done_a_cnt;
    do_load(40);
    check("sv_busy", int'(bus_a.busy), 0);
    repeat (3) @(negedge clk);
    check("sv_done_cnt", done_a_cnt - d0, 0);
    rate = 8'd3;
    do_load(60);
    repeat (3) @(negedge clk);
    do_load(70);
    check("col_nostep", int'(bus_a.dc), 40);
    repeat (3) @(negedge clk);
    check("col_restart", int'(bus_a.dc), 40);
    @(negedge clk);
    check("col_step", int'(bus_a.dc), 41);

`ifdef DUTY_RAMP_KILL_EN
    // Kill mid-ramp, together with a load.
    do_reset();
    rate = '0;
    do_load(100);
    for (int i = 0; i < 200 && bus_a.dc != 7'd60; i++) @(negedge clk);
    check("kill_reach60", int'(bus_a.dc), 60);
    kill = 1'b1;
    target = 7'd80;
    load = 1'b1;
    @(negedge clk);
    kill = 1'b0;
    load = 1'b0;
    check("kill_dc", int'(bus_a.dc), 0);
    check("kill_busy", int'(bus_a.busy), 0);
    check("kill_done", int'(bus_a.done), 0);
    repeat (10) @(negedge clk);
    check("kill_hold", int'(bus_a.dc), 0);
`endif

    // Randomized traffic, checked by the compare process every cycle.
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      load = ($urandom_range(0, 11) == 0);
      target = 7'($urandom_range(0, 127));
      if ($urandom_range(0, 49) == 0) rate = RATE_W'($urandom_range(0, 3));
`ifdef DUTY_RAMP_KILL_EN
      kill = ($urandom_range(0, 199) == 0);
`endif
      @(negedge clk);
    end
    load = 1'b0;
    kill = 1'b0;
    // Let any ramp finish (bounded: 100 steps at rate<=3).
    lim = 0;
    while (lim < 500 && bus_a.busy) begin
      @(negedge clk);
      lim++;
    end
    check("final_idle", int'(bus_a.busy), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
